fpga_operand_entry: RTL

//  Input front-end for the FPGA ALU demo. Converts raw board inputs (KEY[3:0], SW[17:0]) into

---
 rtl/fpga_operand_entry.sv | 101 ++++++++++
 1 files changed

// File: rtl/fpga_operand_entry.sv
// Board-input front end for the ALU demo: synchronises KEY/SW, debounces KEY[3:0] and SW[17],
// and captures operand B on each debounced rising edge of SW[17].
module fpga_operand_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [3:0]  KEY,
  input  logic [17:0] SW,
  output logic [31:0] opA,
  output logic [31:0] opB,
  output logic [3:0]  aluop,
  output logic        b_load,
  output logic        b_valid
);

  localparam int NumDeb = 5;
  // Debouncer lanes: [3:0] = KEY, [4] = SW[17]. Keys idle high, the strobe idles low.
  localparam logic [NumDeb-1:0] DebRst = 5'b0_1111;
  localparam logic [CNT_W-1:0]  CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {StStable, StCount} deb_st_e;

  logic [3:0]        key_s1_q, key_s2_q;
  logic [17:0]       sw_s1_q, sw_s2_q;
  logic [NumDeb-1:0] deb_s, deb_q, deb_d;
  deb_st_e           st_q  [NumDeb];
  deb_st_e           st_d  [NumDeb];
  logic [CNT_W-1:0]  cnt_q [NumDeb];
  logic [CNT_W-1:0]  cnt_d [NumDeb];
  logic              sw17_rise;

  assign deb_s     = {sw_s2_q[17], key_s2_q};
  assign opA       = {{16{sw_s2_q[16]}}, sw_s2_q[15:0]};
  assign sw17_rise = deb_d[4] & ~deb_q[4];

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NumDeb; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      unique case (st_q[i])
        StStable: begin
          if (deb_s[i] != deb_q[i]) begin
            st_d[i]  = StCount;
            cnt_d[i] = CNT_W'(1);
          end
        end
        StCount: begin
          if (deb_s[i] == deb_q[i]) begin
            st_d[i]  = StStable;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CntMax) begin
            deb_d[i] = deb_s[i];
            st_d[i]  = StStable;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      key_s1_q <= 4'hF;
      key_s2_q <= 4'hF;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      deb_q    <= DebRst;
      for (int i = 0; i < NumDeb; i++) begin
        st_q[i]  <= StStable;
        cnt_q[i] <= '0;
      end
      opB      <= '0;
      aluop    <= '0;
      b_load   <= 1'b0;
      b_valid  <= 1'b0;
    end else begin
      key_s1_q <= KEY;
      key_s2_q <= key_s1_q;
      sw_s1_q  <= SW;
      sw_s2_q  <= sw_s1_q;
      deb_q    <= deb_d;
      for (int i = 0; i < NumDeb; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      aluop    <= ~deb_q[3:0];
      // Capture on the same edge the debounced strobe rises; b_load flags it for one cycle.
      b_load   <= sw17_rise;
      if (sw17_rise) begin
        opB     <= opA;
        b_valid <= 1'b1;
      end
    end
  end

endmodule
